// File: rtl/wave_generator_pkg.sv
// -----------------------------------------------------------------------------
// wave_generator_pkg
// Shared types and constants for the multi-channel audio waveform source.
//   wave_mode_t : per-channel waveform selection (2 bits on the mode bus)
//   LATENCY     : clock edges from a sample_tick edge to the level update.
//                 It is 3 when WAVE_GENERATOR_AMPLITUDE_EN is defined, because
//                 the amplitude shifter adds a register stage, and 2 otherwise.
// -----------------------------------------------------------------------------
package wave_generator_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SILENT   = 2'd3
  } wave_mode_t;

`ifdef WAVE_GENERATOR_AMPLITUDE_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif

endpackage

// File: rtl/wave_generator_shaper.sv
// -----------------------------------------------------------------------------
// wave_shaper
// Combinational mapping of one channel's phase accumulator to a signed sample.
//   phase  : in  PHASE_WIDTH  unsigned phase, one full cycle = 2^PHASE_WIDTH
//   mode   : in  wave_mode_t  waveform selection
//   sample : out BIT_WIDTH    signed two's-complement sample
// Parameters: BIT_WIDTH (>= 8), PHASE_WIDTH (>= BIT_WIDTH+1).
// -----------------------------------------------------------------------------
module wave_shaper
  import wave_generator_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int PHASE_WIDTH = 24
) (
  input  logic [PHASE_WIDTH-1:0] phase,
  input  wave_mode_t             mode,
  output logic [BIT_WIDTH-1:0]   sample
);

  logic [BIT_WIDTH-1:0] top_s;
  logic [BIT_WIDTH-1:0] low_s;
  logic [BIT_WIDTH-1:0] tri_s;
  logic                 msb_s;
  logic                 unused_phase_s;

  assign top_s = phase[PHASE_WIDTH-1 -: BIT_WIDTH];
  assign low_s = phase[PHASE_WIDTH-2 -: BIT_WIDTH];
  assign msb_s = phase[PHASE_WIDTH-1];

  // Fractional phase bits below the sample resolution never reach the output.
  assign unused_phase_s = ^phase;

  // Fold the second half-cycle back down so the ramp rises then falls.
  assign tri_s = msb_s ? ~low_s : low_s;

  // Select the waveform; flipping the MSB turns an offset-binary value into
  // two's complement centred on zero.
  always_comb begin
    sample = {BIT_WIDTH{1'b0}};
    case (mode)
      WAVE_SAW:      sample = {~top_s[BIT_WIDTH-1], top_s[BIT_WIDTH-2:0]};
      WAVE_SQUARE: begin
        if (msb_s) begin
          sample = {1'b1, {(BIT_WIDTH-1){1'b0}}};
        end else begin
          sample = {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
      end
      WAVE_TRIANGLE: sample = {~tri_s[BIT_WIDTH-1], tri_s[BIT_WIDTH-2:0]};
      WAVE_SILENT:   sample = {BIT_WIDTH{1'b0}};
      default:       sample = {BIT_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/wave_generator.sv
// -----------------------------------------------------------------------------
// wave_generator
// Multi-channel audio waveform source feeding the HDMI audio packetiser.
// Each channel's phase accumulator advances by its increment on sample_tick;
// the phase is shaped into a saw/square/triangle/silent sample and presented
// on a valid/ready output with a sticky overrun flag.
// Ports:
//   clk_audio   in   audio clock
//   reset       in   asynchronous active-high reset
//   sample_tick in   one-cycle strobe, advances all phases by one sample
//   increment   in   CHANNELS*PHASE_WIDTH unsigned increments, ch0 in LSBs
//   mode        in   CHANNELS*2 wave_mode_t selections, ch0 in LSBs
//   amp_shift   in   CHANNELS*4 arithmetic right shift per channel
//                    (present only with WAVE_GENERATOR_AMPLITUDE_EN)
//   sync_clear  in   zero all phase accumulators (wins over sample_tick)
//   level       out  CHANNELS*BIT_WIDTH signed samples, ch0 in LSBs
//   level_valid out  level holds an unconsumed sample set
//   level_ready in   consumer accepts level while level_valid=1
//   overrun     out  sticky: a set was overwritten before being consumed
// Configuration macro: WAVE_GENERATOR_AMPLITUDE_EN (adds amp_shift and one
// pipeline stage; latency 3 instead of 2).
// -----------------------------------------------------------------------------
module wave_generator
  import wave_generator_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int CHANNELS    = 2
) (
  input  logic                            clk_audio,
  input  logic                            reset,
  input  logic                            sample_tick,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] increment,
  input  logic [CHANNELS*2-1:0]           mode,
`ifdef WAVE_GENERATOR_AMPLITUDE_EN
  input  logic [CHANNELS*4-1:0]           amp_shift,
`endif
  input  logic                            sync_clear,
  output logic [CHANNELS*BIT_WIDTH-1:0]   level,
  output logic                            level_valid,
  input  logic                            level_ready,
  output logic                            overrun
);

  logic                          s1_valid_r;
  logic                          s2_valid_r;
  logic                          pipe_valid_s;
  logic [CHANNELS*BIT_WIDTH-1:0] pipe_level_s;
  logic [CHANNELS*BIT_WIDTH-1:0] level_r;
  logic                          level_valid_r;
  logic                          overrun_r;
`ifdef WAVE_GENERATOR_AMPLITUDE_EN
  logic                          s3_valid_r;
`endif

  // Valid bits travel alongside the per-channel data through the pipeline.
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
`ifdef WAVE_GENERATOR_AMPLITUDE_EN
      s3_valid_r <= 1'b0;
`endif
    end else begin
      s1_valid_r <= sample_tick;
      s2_valid_r <= s1_valid_r;
`ifdef WAVE_GENERATOR_AMPLITUDE_EN
      s3_valid_r <= s2_valid_r;
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PHASE_WIDTH-1:0] phase_r;
    wave_mode_t             mode_r;
    logic [BIT_WIDTH-1:0]   shaped_s;
    logic [BIT_WIDTH-1:0]   s2_level_r;

    // Stage 1: phase accumulator; mode is captured with the tick so a later
    // mode change cannot alter a sample already in flight.
    always_ff @(posedge clk_audio or posedge reset) begin
      if (reset) begin
        phase_r <= {PHASE_WIDTH{1'b0}};
        mode_r  <= WAVE_SILENT;
      end else begin
        if (sample_tick) begin
          mode_r <= wave_mode_t'(mode[2*c +: 2]);
        end
        if (sync_clear) begin
          phase_r <= {PHASE_WIDTH{1'b0}};
        end else if (sample_tick) begin
          phase_r <= phase_r + increment[c*PHASE_WIDTH +: PHASE_WIDTH];
        end
      end
    end

    wave_shaper #(
      .BIT_WIDTH   (BIT_WIDTH),
      .PHASE_WIDTH (PHASE_WIDTH)
    ) u_shaper (
      .phase  (phase_r),
      .mode   (mode_r),
      .sample (shaped_s)
    );

    // Stage 2: register the shaped sample for the tick that just advanced.
    always_ff @(posedge clk_audio or posedge reset) begin
      if (reset) begin
        s2_level_r <= {BIT_WIDTH{1'b0}};
      end else if (s1_valid_r) begin
        s2_level_r <= shaped_s;
      end
    end

`ifdef WAVE_GENERATOR_AMPLITUDE_EN
    logic [3:0]                  amp1_r;
    logic [3:0]                  amp2_r;
    logic signed [BIT_WIDTH-1:0] s3_level_r;

    // Stage 3: amplitude shift; the shift amount follows its sample down the
    // pipe from the tick edge.
    always_ff @(posedge clk_audio or posedge reset) begin
      if (reset) begin
        amp1_r     <= 4'd0;
        amp2_r     <= 4'd0;
        s3_level_r <= {BIT_WIDTH{1'b0}};
      end else begin
        if (sample_tick) begin
          amp1_r <= amp_shift[4*c +: 4];
        end
        if (s1_valid_r) begin
          amp2_r <= amp1_r;
        end
        if (s2_valid_r) begin
          s3_level_r <= $signed(s2_level_r) >>> amp2_r;
        end
      end
    end

    assign pipe_level_s[c*BIT_WIDTH +: BIT_WIDTH] = s3_level_r;
`else
    assign pipe_level_s[c*BIT_WIDTH +: BIT_WIDTH] = s2_level_r;
`endif
  end

`ifdef WAVE_GENERATOR_AMPLITUDE_EN
  assign pipe_valid_s = s3_valid_r;
`else
  assign pipe_valid_s = s2_valid_r;
`endif

  // Output holding register: an arrival always loads (a simultaneous transfer
  // consumes the old set), an arrival onto an unconsumed set flags overrun.
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      level_r       <= {(CHANNELS*BIT_WIDTH){1'b0}};
      level_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else if (pipe_valid_s) begin
      level_r       <= pipe_level_s;
      level_valid_r <= 1'b1;
      if (level_valid_r && !level_ready) begin
        overrun_r <= 1'b1;
      end
    end else if (level_valid_r && level_ready) begin
      level_valid_r <= 1'b0;
    end
  end

  assign level       = level_r;
  assign level_valid = level_valid_r;
  assign overrun     = overrun_r;

endmodule
